// File: rtl/std_fifo_vr.sv
// Synchronous valid/ready FIFO with wrap-bit pointers, synchronous flush and
// registered-only ready/valid flags; the head word is zeroed while empty.
module std_fifo_vr #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [PTR_WIDTH:0]    count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PTR_WIDTH != $clog2(DEPTH)) begin : g_bad_param
        $error("std_fifo_vr: DEPTH must be a power of two >= 2 and PTR_WIDTH must stay derived");
    end

    localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    wr_ptr;
    logic [PTR_WIDTH:0]    rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Handshake: a word moves on a port only in a cycle where valid and ready
    // are both high at the rising edge. s_ready and m_valid depend only on the
    // pointer registers, never on s_valid or m_ready, so neither side can form
    // a combinational loop through this FIFO.
    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[PTR_WIDTH-1:0] == wr_ptr[PTR_WIDTH-1:0]) &&
                     (rd_ptr[PTR_WIDTH] != wr_ptr[PTR_WIDTH]);
    assign s_ready = !full;
    assign m_valid = !empty;
    assign count   = wr_ptr - rd_ptr;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? mem[rd_ptr[PTR_WIDTH-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately not reset; the write slot is never the head
    // unless the FIFO is empty, so the presented word cannot be disturbed.
    always_ff @(posedge clk) begin
        if (resetn && !flush && push) mem[wr_ptr[PTR_WIDTH-1:0]] <= s_data;
    end

endmodule

// File: tb/tb_std_fifo_vr.sv
// Bench for std_fifo_vr: a queue model predicts flags, count and the head
// word every cycle and pops expected words as the consumer takes them.
module tb_std_fifo_vr;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 4;
    localparam int PTR_WIDTH  = $clog2(DEPTH);

    logic                  clk;
    logic                  resetn;
    logic                  flush;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [PTR_WIDTH:0]    count;

    logic [DATA_WIDTH-1:0] exp_q[$];
    int                    n_checks;
    int                    n_fail;

    std_fifo_vr #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle from the falling edge, check outputs against the model,
    // then advance the model by what the rising edge should do.
    task automatic drive_cycle(input logic sv, input logic [DATA_WIDTH-1:0] sd,
                               input logic mr, input logic fl, input logic rn);
        logic do_push;
        logic do_pop;
        logic [DATA_WIDTH-1:0] exp_head;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        resetn  = rn;
        #1;
        exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
        check_eq("count",   32'(count),   32'(exp_q.size()));
        check_eq("s_ready", 32'(s_ready), 32'(exp_q.size() < DEPTH));
        check_eq("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
        check_eq("m_data",  32'(m_data),  32'(exp_head));
        do_push = sv && (exp_q.size() < DEPTH);
        do_pop  = mr && (exp_q.size() > 0);
        if (!rn || fl) begin
            exp_q.delete();
        end else begin
            if (do_pop) begin
                exp_head = exp_q.pop_front();
                check_eq("pop_data", 32'(m_data), 32'(exp_head));
            end
            if (do_push) exp_q.push_back(sd);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // reset: two edges held low with an offer pending
        resetn  = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        m_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);

        // first word
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        // fill, refused fifth push, drain in order
        for (int i = 1; i <= 5; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        drain();

        // full with concurrent offer: only the pop happens, 0x55 lands next cycle
        for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        // streaming across several pointer wraps
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
        drain();

        // head stability while more words arrive
        drive_cycle(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        // flush with concurrent push and pop
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        drive_cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
        drain();

        // reset and flush together mid-stream
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b1);
        drain();

        // random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0), 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
